// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding controller.
//
// Contents:
//   FWD_NONE   - forward select value meaning "use the ID/EX pipeline register"
//   OP_LOAD    - MIPS load-word opcode, for CPU-side decode of id_is_load
//   SB_AW      - address width stored in a scoreboard entry (covers up to 256
//                registers; narrower register files are zero-extended)
//   sb_entry_t - one in-flight instruction tracked after ID
package pipe_hazard_pkg;

  localparam int FWD_NONE = 0;
  localparam logic [5:0] OP_LOAD = 6'h23;
  localparam int SB_AW = 8;

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic             is_load;
    logic [SB_AW-1:0] addr;
  } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Interface between the CPU pipeline (master) and the hazard unit (slave).
//
// Master drives the ID-stage decode and the EX branch outcome:
//   id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wr_en, id_wr_addr,
//   id_is_load, id_jump, ex_branch_taken
// Slave returns the pipeline controls and EX forward selects:
//   stall, flush_ifid, bubble_idex, fwd_rs, fwd_rt,
//   ex_wr_en, ex_is_load, ex_wr_addr
// With HAZ_PERF_EN defined the slave also returns perf_stall_cnt and
// perf_flush_cnt.
interface pipe_hazard_unit_if #(
  parameter int NREG  = 32,
  parameter int DEPTH = 3
);
  localparam int AW = $clog2(NREG);
  localparam int FW = $clog2(DEPTH + 1);

  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic          id_wr_en;
  logic [AW-1:0] id_wr_addr;
  logic          id_is_load;
  logic          id_jump;
  logic          ex_branch_taken;

  logic          stall;
  logic          flush_ifid;
  logic          bubble_idex;
  logic [FW-1:0] fwd_rs;
  logic [FW-1:0] fwd_rt;
  logic          ex_wr_en;
  logic          ex_is_load;
  logic [AW-1:0] ex_wr_addr;
`ifdef HAZ_PERF_EN
  logic [31:0]   perf_stall_cnt;
  logic [31:0]   perf_flush_cnt;
`endif

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wr_en,
           id_wr_addr, id_is_load, id_jump, ex_branch_taken,
    input  stall, flush_ifid, bubble_idex, fwd_rs, fwd_rt,
           ex_wr_en, ex_is_load, ex_wr_addr
`ifdef HAZ_PERF_EN
    , input perf_stall_cnt, perf_flush_cnt
`endif
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wr_en,
           id_wr_addr, id_is_load, id_jump, ex_branch_taken,
    output stall, flush_ifid, bubble_idex, fwd_rs, fwd_rt,
           ex_wr_en, ex_is_load, ex_wr_addr
`ifdef HAZ_PERF_EN
    , output perf_stall_cnt, perf_flush_cnt
`endif
  );

endinterface

// File: rtl/hazard_src_match.sv
// Compares one ID source operand against every scoreboard entry.
//
// Ports:
//   id_valid_i  - ID holds a real instruction
//   used_i      - this operand is actually read
//   src_i       - source register address (zero-extended to SB_AW)
//   entries_i   - current scoreboard, index 0 = youngest (EX)
//   fwd_sel_o   - j+1 of the youngest producer that will still be in the
//                 pipeline when the consumer reaches EX, else FWD_NONE
//   stall_req_o - a matching load is too young to be forwarded
module hazard_src_match
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_AVAIL = 2,
  parameter int FW         = 2
) (
  input  logic             id_valid_i,
  input  logic             used_i,
  input  logic [SB_AW-1:0] src_i,
  input  sb_entry_t        entries_i [DEPTH],
  output logic [FW-1:0]    fwd_sel_o,
  output logic             stall_req_o
);

  logic [DEPTH-1:0] hit;

  // $zero is never a dependency: writes to it are discarded by the regfile.
  always_comb begin
    hit = '0;
    for (int j = 0; j < DEPTH; j++) begin
      hit[j] = id_valid_i && used_i && (src_i != '0) &&
               entries_i[j].valid && entries_i[j].wr_en &&
               (entries_i[j].addr == src_i);
    end
  end

  // Scan oldest to youngest so the youngest producer is the last writer.
  // Entry DEPTH-1 retires before the consumer reaches EX; the regfile
  // write-through covers it, so it is excluded from forwarding.
  always_comb begin
    fwd_sel_o   = FW'(FWD_NONE);
    stall_req_o = 1'b0;
    for (int j = DEPTH - 2; j >= 0; j--) begin
      if (hit[j]) fwd_sel_o = FW'(j + 1);
    end
    // A load in entry j will sit in entry j+1 when the consumer is in EX;
    // its data only exists from entry LOAD_AVAIL onwards.
    for (int j = 0; j < DEPTH; j++) begin
      if (hit[j] && entries_i[j].is_load && (j + 1 < LOAD_AVAIL))
        stall_req_o = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the in-order MIPS pipeline.
//
// Tracks the destination of every instruction past ID in a DEPTH-entry
// scoreboard (entry 0 = EX) and derives from it the load-use stall, the
// IF/ID flush and ID/EX bubble controls, and registered per-operand forward
// selects for EX.
//
// Ports:
//   clk   - pipeline clock
//   reset - asynchronous, active-low; clears the scoreboard and forces
//           every output to 0 while asserted
//   hz    - pipe_hazard_unit_if slave modport (ID decode in, controls out)
//
// Optional build macro HAZ_PERF_EN adds saturating perf_stall_cnt and
// perf_flush_cnt counters on the interface.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int NREG       = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_AVAIL = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_hazard_unit_if.slave    hz
);

  localparam int AW = $clog2(NREG);
  localparam int FW = $clog2(DEPTH + 1);

  sb_entry_t     sb_q [DEPTH];
  sb_entry_t     sb_d [DEPTH];
  logic [FW-1:0] fwd_rs_q, fwd_rs_d;
  logic [FW-1:0] fwd_rt_q, fwd_rt_d;

  logic [FW-1:0] rs_sel, rt_sel;
  logic          rs_stall, rt_stall;
  logic          stall_c, flush_c, bubble_c;

  hazard_src_match #(
    .DEPTH      (DEPTH),
    .LOAD_AVAIL (LOAD_AVAIL),
    .FW         (FW)
  ) u_match_rs (
    .id_valid_i  (hz.id_valid),
    .used_i      (hz.id_rs_used),
    .src_i       (SB_AW'(hz.id_rs)),
    .entries_i   (sb_q),
    .fwd_sel_o   (rs_sel),
    .stall_req_o (rs_stall)
  );

  hazard_src_match #(
    .DEPTH      (DEPTH),
    .LOAD_AVAIL (LOAD_AVAIL),
    .FW         (FW)
  ) u_match_rt (
    .id_valid_i  (hz.id_valid),
    .used_i      (hz.id_rt_used),
    .src_i       (SB_AW'(hz.id_rt)),
    .entries_i   (sb_q),
    .fwd_sel_o   (rt_sel),
    .stall_req_o (rt_stall)
  );

  // Pipeline controls are combinational. A taken branch kills the ID
  // instruction, so it overrides any stall; a jump only redirects once the
  // stall has cleared (ID is held, so the jump is still there). Reset
  // gates everything to 0 without waiting for a clock.
  always_comb begin
    stall_c  = reset && hz.id_valid && (rs_stall || rt_stall) &&
               !hz.ex_branch_taken;
    flush_c  = reset && (hz.ex_branch_taken || (hz.id_jump && !stall_c));
    bubble_c = reset && (hz.ex_branch_taken || stall_c);
  end

  // Next scoreboard: shift toward retirement, entry 0 takes the ID
  // instruction unless it is bubbled or absent.
  always_comb begin
    sb_d[0] = '0;
    if (hz.id_valid && !bubble_c) begin
      sb_d[0].valid   = 1'b1;
      sb_d[0].wr_en   = hz.id_wr_en;
      sb_d[0].is_load = hz.id_is_load;
      sb_d[0].addr    = SB_AW'(hz.id_wr_addr);
    end
    for (int k = 1; k < DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    fwd_rs_d = bubble_c ? FW'(FWD_NONE) : rs_sel;
    fwd_rt_d = bubble_c ? FW'(FWD_NONE) : rt_sel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= '0;
      end
      fwd_rs_q <= '0;
      fwd_rt_q <= '0;
    end else begin
      sb_q     <= sb_d;
      fwd_rs_q <= fwd_rs_d;
      fwd_rt_q <= fwd_rt_d;
    end
  end

  assign hz.stall       = stall_c;
  assign hz.flush_ifid  = flush_c;
  assign hz.bubble_idex = bubble_c;
  assign hz.fwd_rs      = fwd_rs_q;
  assign hz.fwd_rt      = fwd_rt_q;
  // Invalid entries are stored as all-zero, so the raw fields are already
  // qualified.
  assign hz.ex_wr_en    = sb_q[0].wr_en;
  assign hz.ex_is_load  = sb_q[0].is_load;
  assign hz.ex_wr_addr  = sb_q[0].addr[AW-1:0];

`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_c) perf_stall_q <= sat_inc(perf_stall_q);
      if (flush_c) perf_flush_q <= sat_inc(perf_flush_q);
    end
  end

  assign hz.perf_stall_cnt = perf_stall_q;
  assign hz.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: DUT A (DEPTH=3, LOAD_AVAIL=2) and
// DUT B (DEPTH=4, LOAD_AVAIL=3). Each directed cycle pushes its expected
// outputs; the monitor pops and compares at the falling edge.
module tb_pipe_hazard_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.NREG(32), .DEPTH(3)) ifa ();
  pipe_hazard_unit_if #(.NREG(32), .DEPTH(4)) ifb ();

  pipe_hazard_unit #(.NREG(32), .DEPTH(3), .LOAD_AVAIL(2)) u_dut_a (
    .clk(clk), .reset(reset), .hz(ifa));
  pipe_hazard_unit #(.NREG(32), .DEPTH(4), .LOAD_AVAIL(3)) u_dut_b (
    .clk(clk), .reset(reset), .hz(ifb));

  // Stimulus variables, steered to the selected DUT; the other sees idle.
  bit         cur_dut;
  logic       s_valid, s_rs_used, s_rt_used, s_wr_en, s_is_load, s_jump, s_br;
  logic [4:0] s_rs, s_rt, s_wr_addr;

  assign ifa.id_valid        = !cur_dut && s_valid;
  assign ifa.id_rs           = cur_dut ? 5'd0 : s_rs;
  assign ifa.id_rt           = cur_dut ? 5'd0 : s_rt;
  assign ifa.id_rs_used      = !cur_dut && s_rs_used;
  assign ifa.id_rt_used      = !cur_dut && s_rt_used;
  assign ifa.id_wr_en        = !cur_dut && s_wr_en;
  assign ifa.id_wr_addr      = cur_dut ? 5'd0 : s_wr_addr;
  assign ifa.id_is_load      = !cur_dut && s_is_load;
  assign ifa.id_jump         = !cur_dut && s_jump;
  assign ifa.ex_branch_taken = !cur_dut && s_br;

  assign ifb.id_valid        = cur_dut && s_valid;
  assign ifb.id_rs           = cur_dut ? s_rs : 5'd0;
  assign ifb.id_rt           = cur_dut ? s_rt : 5'd0;
  assign ifb.id_rs_used      = cur_dut && s_rs_used;
  assign ifb.id_rt_used      = cur_dut && s_rt_used;
  assign ifb.id_wr_en        = cur_dut && s_wr_en;
  assign ifb.id_wr_addr      = cur_dut ? s_wr_addr : 5'd0;
  assign ifb.id_is_load      = cur_dut && s_is_load;
  assign ifb.id_jump         = cur_dut && s_jump;
  assign ifb.ex_branch_taken = cur_dut && s_br;

  typedef struct {
    bit    dut;
    int    stall, flush, bubble, frs, frt, we, ld, addr;
    bit    chk_perf;
    int    pst, pfl;
    string tag;
  } exp_t;

  exp_t exq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  event sample_ev;

  task automatic cmp(input string tag, input string fld, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0d expected=%0d", tag, fld, act, req);
    end
  endtask

  // Monitor: pops one expectation per falling edge (or explicit sample).
  always begin
    @(negedge clk or sample_ev);
    if (exq.size() > 0) begin
      mon_e = exq.pop_front();
      if (!mon_e.dut) begin
        cmp(mon_e.tag, "stall",  int'(ifa.stall),       mon_e.stall);
        cmp(mon_e.tag, "flush",  int'(ifa.flush_ifid),  mon_e.flush);
        cmp(mon_e.tag, "bubble", int'(ifa.bubble_idex), mon_e.bubble);
        cmp(mon_e.tag, "fwd_rs", int'(ifa.fwd_rs),      mon_e.frs);
        cmp(mon_e.tag, "fwd_rt", int'(ifa.fwd_rt),      mon_e.frt);
        cmp(mon_e.tag, "ex_we",  int'(ifa.ex_wr_en),    mon_e.we);
        cmp(mon_e.tag, "ex_ld",  int'(ifa.ex_is_load),  mon_e.ld);
        cmp(mon_e.tag, "ex_ad",  int'(ifa.ex_wr_addr),  mon_e.addr);
`ifdef HAZ_PERF_EN
        if (mon_e.chk_perf) begin
          cmp(mon_e.tag, "perf_stall", int'(ifa.perf_stall_cnt), mon_e.pst);
          cmp(mon_e.tag, "perf_flush", int'(ifa.perf_flush_cnt), mon_e.pfl);
        end
`endif
      end else begin
        cmp(mon_e.tag, "stall",  int'(ifb.stall),       mon_e.stall);
        cmp(mon_e.tag, "flush",  int'(ifb.flush_ifid),  mon_e.flush);
        cmp(mon_e.tag, "bubble", int'(ifb.bubble_idex), mon_e.bubble);
        cmp(mon_e.tag, "fwd_rs", int'(ifb.fwd_rs),      mon_e.frs);
        cmp(mon_e.tag, "fwd_rt", int'(ifb.fwd_rt),      mon_e.frt);
        cmp(mon_e.tag, "ex_we",  int'(ifb.ex_wr_en),    mon_e.we);
        cmp(mon_e.tag, "ex_ld",  int'(ifb.ex_is_load),  mon_e.ld);
        cmp(mon_e.tag, "ex_ad",  int'(ifb.ex_wr_addr),  mon_e.addr);
      end
    end
  end

  task automatic push(input string tag, input int s, f, b, frs, frt, we, ld, addr,
                      input bit cp = 1'b0, input int pst = 0, input int pfl = 0);
    exp_t e;
    e.dut = cur_dut; e.stall = s; e.flush = f; e.bubble = b;
    e.frs = frs; e.frt = frt; e.we = we; e.ld = ld; e.addr = addr;
    e.chk_perf = cp; e.pst = pst; e.pfl = pfl; e.tag = tag;
    exq.push_back(e);
  endtask

  task automatic drv(input bit v, input int rs, rt, input bit ru, tu, we,
                     input int wa, input bit ld, jmp, br);
    s_valid = v; s_rs = 5'(rs); s_rt = 5'(rt); s_rs_used = ru; s_rt_used = tu;
    s_wr_en = we; s_wr_addr = 5'(wa); s_is_load = ld; s_jump = jmp; s_br = br;
  endtask

  task automatic alu(input int rd, rs, rt); drv(1, rs, rt, 1, 1, 1, rd, 0, 0, 0); endtask
  task automatic lw(input int rd, base);    drv(1, base, 0, 1, 0, 1, rd, 1, 0, 0); endtask
  task automatic idle(input bit br);        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, br); endtask
  task automatic cyc(); @(posedge clk); #1; endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    cur_dut = 1'b0;
    reset   = 1'b0;
    drv(1, 8, 8, 1, 1, 1, 9, 1, 1, 1);
    // Held in reset with every input active: outputs must stay 0.
    cyc(); push("rst0", 0,0,0, 0,0, 0,0,0);
    cyc(); push("rst1", 0,0,0, 0,0, 0,0,0);
    @(negedge clk); #2; reset = 1'b1; idle(0);

    cyc(); idle(0);          push("c0_idle",      0,0,0, 0,0, 0,0,0);
    cyc(); alu(8, 1, 2);     push("c1_add8",      0,0,0, 0,0, 0,0,0);
    cyc(); alu(9, 8, 8);     push("c2_b2b",       0,0,0, 0,0, 1,0,8);
    cyc(); alu(10, 1, 2);    push("c3_fwd1",      0,0,0, 1,1, 1,0,9);
    cyc(); alu(11, 9, 8);    push("c4_spacer",    0,0,0, 0,0, 1,0,10);
    cyc(); lw(8, 1);         push("c5_fwd2_wt",   0,0,0, 2,0, 1,0,11);
    cyc(); alu(9, 8, 3);     push("c6_lduse",     1,0,1, 0,0, 1,1,8);
    cyc(); alu(9, 8, 3);     push("c7_release",   0,0,0, 0,0, 0,0,0);
    cyc(); lw(0, 1);         push("c8_ldfwd2",    0,0,0, 2,0, 1,0,9);
    cyc(); alu(12, 0, 0);    push("c9_zero",      0,0,0, 0,0, 1,1,0);
    cyc(); lw(8, 1);         push("c10_zerofwd",  0,0,0, 0,0, 1,0,12);
    cyc(); drv(1, 8, 8, 0, 0, 0, 0, 0, 1, 0);
                             push("c11_j_unused", 0,1,0, 0,0, 1,1,8);
    cyc(); alu(8, 1, 2);     push("c12_after_j",  0,0,0, 0,0, 0,0,0);
    cyc(); alu(8, 8, 1);     push("c13_prod2",    0,0,0, 0,0, 1,0,8);
    cyc(); alu(13, 8, 8);    push("c14_use",      0,0,0, 1,0, 1,0,8);
    cyc(); lw(8, 1);         push("c15_youngest", 0,0,0, 1,1, 1,0,13);
    cyc(); drv(1, 8, 8, 1, 1, 1, 9, 0, 0, 1);
                             push("c16_br_wins",  0,1,1, 0,0, 1,1,8);
    cyc(); idle(0);          push("c17_killed",   0,0,0, 0,0, 0,0,0);
    cyc(); lw(7, 1);         push("c18_lw7",      0,0,0, 0,0, 0,0,0);
    cyc(); drv(1, 7, 0, 1, 0, 0, 0, 0, 1, 0);
                             push("c19_jr_stall", 1,0,1, 0,0, 1,1,7);
    cyc(); drv(1, 7, 0, 1, 0, 0, 0, 0, 1, 0);
                             push("c20_jr_go",    0,1,0, 0,0, 0,0,0);
    cyc(); lw(8, 1);         push("c21_jr_fwd",   0,0,0, 2,0, 0,0,0);
    cyc(); alu(9, 8, 8);     push("c22_stall",    1,0,1, 0,0, 1,1,8);
    // Reset mid-stall, between clock edges.
    @(negedge clk); #2; reset = 1'b0; drv(1, 8, 8, 1, 1, 1, 9, 0, 1, 1);
    #1; push("rst_async", 0,0,0, 0,0, 0,0,0); ->sample_ev;
    cyc();                   push("rst_hold",     0,0,0, 0,0, 0,0,0);
    @(negedge clk); #2; reset = 1'b1; idle(0);
    cyc(); alu(9, 8, 8);     push("c24_post_rst", 0,0,0, 0,0, 0,0,0);
    cyc(); idle(0);          push("c25_nofwd",    0,0,0, 0,0, 1,0,9);

    // DUT B: load result only forwardable from entry 3 -> two stall cycles.
    cur_dut = 1'b1;
    cyc(); lw(8, 1);         push("b0_lw",        0,0,0, 0,0, 0,0,0);
    cyc(); alu(9, 8, 8);     push("b1_stall",     1,0,1, 0,0, 1,1,8);
    cyc(); alu(9, 8, 8);     push("b2_stall",     1,0,1, 0,0, 0,0,0);
    cyc(); alu(9, 8, 8);     push("b3_go",        0,0,0, 0,0, 0,0,0);
    cyc(); idle(0);          push("b4_fwd3",      0,0,0, 3,3, 1,0,9);

    // DUT A: three load-use stalls, then two taken branches.
    cur_dut = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(); lw(8, 1);
      if (k == 0) push("p_lw",   0,0,0, 0,0, 0,0,0);
      else        push("p_lw",   0,0,0, 2,2, 1,0,9);
      cyc(); alu(9, 8, 8);   push("p_stall",      1,0,1, 0,0, 1,1,8);
      cyc(); alu(9, 8, 8);   push("p_go",         0,0,0, 0,0, 0,0,0);
    end
    cyc(); idle(1);          push("p_br1",        0,1,1, 2,2, 1,0,9);
    cyc(); idle(1);          push("p_br2",        0,1,1, 0,0, 0,0,0);
    cyc(); idle(0);          push("p_perf",       0,0,0, 0,0, 0,0,0, 1'b1, 3, 2);

    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exq.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain actual=%0d expected=0", exq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the in-order MIPS pipeline (IF/ID/EX/MEM/WB and deeper variants).
- Keeps a scoreboard shift register of in-flight destination registers past ID.
- From it, generates the load-use stall, IF/ID and ID/EX flush/bubble controls, and registered per-operand forward selects for the EX stage.
- Replaces ad-hoc hazard wiring in the CPU top. Generalised over register count, post-ID pipeline depth and load latency; $zero and unused-operand qualification are built in.

Parameters:
- NREG, 32, architectural register count; AW = $clog2(NREG).
- DEPTH, 3, tracked stages after ID (entry 0 = EX, 1 = MEM, 2 = WB); minimum 2.
- LOAD_AVAIL, 2, first entry index whose load result is forwardable into EX; range 1..DEPTH-1.
- FW, $clog2(DEPTH+1), width of the forward select.

Ports:
- clk  in  1  pipeline clock (slow_clk domain)
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  AW  ID source register addresses
- id_rs_used, id_rt_used  in  1  the operand is actually read
- id_wr_en  in  1  ID instruction writes a register
- id_wr_addr  in  AW  its final destination (after RegDst)
- id_is_load  in  1  ID instruction is a load
- id_jump  in  1  j/jal/jr resolved in ID
- ex_branch_taken  in  1  branch in EX is taken
- stall  out  1  hold PC and IF/ID
- flush_ifid  out  1  IF/ID loads a NOP
- bubble_idex  out  1  ID/EX loads a NOP
- fwd_rs, fwd_rt  out  FW  EX operand source: 0 = pipeline register; k = result of entry k
- ex_wr_en, ex_is_load  out  1  entry 0 flags
- ex_wr_addr  out  AW  entry 0 destination

Behaviour:
- Scoreboard: DEPTH entries {valid, wr_en, is_load, addr}; registered, async-cleared.
- Each clk edge, entries shift k → k+1 and entry DEPTH-1 retires. Entry 0 loads the ID instruction, or an invalid bubble when bubble_idex = 1.
- Match(src, j): src_used && src != 0 && entry j valid && wr_en && addr == src. Combinational, against current entries.
- Load-use stall: stall = id_valid && ∃ j with Match && entry j is_load && j+1 < LOAD_AVAIL. ALU results are forwardable from entry ≥ 1, so they never stall.
- Forward select: at the edge where ID enters entry 0, fwd_x is registered as j+1 for the smallest j (youngest producer) satisfying Match with j+1 ≤ DEPTH-1. Otherwise 0. Producers that retire before the consumer reaches EX are covered by the RegisterFile write-through.
- When an instruction is bubbled, fwd_rs/fwd_rt register 0.
- flush_ifid = ex_branch_taken || (id_jump && !stall).
- bubble_idex = ex_branch_taken || stall.
- Branch taken during a stall: stall is forced to 0 (branch wins). The ID instruction is killed and does not enter entry 0.
- id_jump during a stall: ignored until the stall clears. The jump re-asserts because ID is held.
- id_valid = 0: no stall, no match contribution; entry 0 becomes a bubble.
- Reset asserted (including mid-operation): all entries invalid; all outputs 0, immediately and asynchronously. Normal operation resumes on the first edge after release.
- Latency: stall, flush and bubble outputs are same-cycle combinational. fwd_* and ex_* are one cycle, registered.

Optional Feature:
- Macro HAZ_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], cleared by reset. They count cycles with stall = 1 and cycles with flush_ifid = 1 respectively, saturating at 32'hFFFF_FFFF. They can be shown via show_control on the 7-segment display.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package pipe_hazard_pkg:
  - FWD_NONE = 0 constant.
  - Scoreboard entry struct (valid, wr_en, is_load, addr).
  - LOAD opcode constant 6'h23.
- Sub-module hazard_src_match: one per source operand. Compares one source against all entries and returns the youngest match index and the stall request.

Test Plan:
- Back-to-back ALU: add $8 ← …, then add $9 ← $8,$8 → no stall; fwd_rs = fwd_rt = 1 next cycle. One spacer instruction → fwd = 2.
- Load-use: lw $8, then add $9 ← $8 → stall = 1 and bubble_idex = 1 for exactly 1 cycle, then fwd_rs = 2.
- With LOAD_AVAIL = 3 and DEPTH = 4 → 2 stall cycles.
- $zero / unused operand: lw $0, then add using $0; and lw $8, then j (rs unused) → stall = 0, fwd = 0.
- Two producers of $8 in entries 0 and 1 → fwd selects 1 (youngest).
- Simultaneous lw-use stall and ex_branch_taken → stall = 0, flush_ifid = 1, bubble_idex = 1; entry 0 is invalid next cycle.
- Reset driven low mid-stall → outputs 0 asynchronously. After release, first add $9 ← $8 → no stall; fwd = 0.
- With HAZ_PERF_EN: 3 load-use stalls plus 2 taken branches → perf_stall_cnt = 3, perf_flush_cnt = 2.
